// File: rtl/hilo_mult_unit_if.sv
// Handshake and data bundle between the decoder/pipeline and the HI/LO
// multiply unit. The pipeline side is the master; the multiply unit is the slave.
interface hilo_mult_unit_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        mfhi;
    logic        mflo;
    logic [31:0] hilo_out;
    logic        busy;
    logic        done;
    logic        stall;

    modport master (
        output start, a, b, mfhi, mflo,
        input  hilo_out, busy, done, stall
    );

    modport slave (
        input  start, a, b, mfhi, mflo,
        output hilo_out, busy, done, stall
    );
endinterface

// File: rtl/hilo_mult_unit.sv
// Iterative 32x32 unsigned multiplier (MULTU) with HI/LO result registers.
// One radix-2 shift-add step per cycle, fixed 32-cycle run, one-cycle DONE.
// HI/LO are read combinationally through MFHI/MFLO; stall tells the
// pipeline that a read or a new multiply must wait for the running one.
module hilo_mult_unit (
    input  logic              clk,
    input  logic              reset,
    hilo_mult_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        load_s;
    logic        step_s;
    logic        last_s;

    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [63:0] acc_r;
    logic [4:0]  cnt_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic [63:0] addend_s;
    logic [63:0] acc_sum_s;

    // State register: IDLE after reset, otherwise follows the next-state logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath control: start is honoured only in IDLE or DONE.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        step_s  = 1'b0;
        last_s  = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    load_s  = 1'b1;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == 5'd31) begin
                    last_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // One shift-add step: add the multiplicand shifted by the bit position when that multiplier bit is set.
    always_comb begin
        addend_s = 64'd0;
        if (b_r[cnt_r]) begin
            addend_s = {32'd0, a_r} << cnt_r;
        end else begin
            addend_s = 64'd0;
        end
        acc_sum_s = acc_r + addend_s;
    end

    // Operand latch, accumulator and counter; HI/LO written only on the final step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r   <= 32'd0;
            b_r   <= 32'd0;
            acc_r <= 64'd0;
            cnt_r <= 5'd0;
            hi_r  <= 32'd0;
            lo_r  <= 32'd0;
        end else if (load_s) begin
            a_r   <= bus.a;
            b_r   <= bus.b;
            acc_r <= 64'd0;
            cnt_r <= 5'd0;
        end else if (step_s) begin
            acc_r <= acc_sum_s;
            cnt_r <= cnt_r + 5'd1;
            if (last_s) begin
                hi_r <= acc_sum_s[63:32];
                lo_r <= acc_sum_s[31:0];
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    // Status decoded straight from the state register, and the HI/LO read mux (MFHI wins over MFLO).
    always_comb begin
        bus.busy  = (state_r == RUN);
        bus.done  = (state_r == DONE);
        bus.stall = (state_r == RUN) & (bus.start | bus.mfhi | bus.mflo);
        if (bus.mfhi) begin
            bus.hilo_out = hi_r;
        end else if (bus.mflo) begin
            bus.hilo_out = lo_r;
        end else begin
            bus.hilo_out = 32'd0;
        end
    end

endmodule
